// File: rtl/gtp_chan_rx_if.sv
// Link-side bundle for gtp_chan_rx: raw GTP RX word and channel select in,
// filtered samples and link status out.
interface gtp_chan_rx_if;
    logic [15:0] DATA_I;
    logic [1:0]  CHARISK_I;
    logic [3:0]  CHSEL;
    logic        ERRCLR;
    logic [11:0] DOUT;
    logic        DVALID;
    logic        LOCKED;
    logic [15:0] ERRCNT;
    logic [1:0]  STATE;

    modport master (output DATA_I, CHARISK_I, CHSEL, ERRCLR,
                    input  DOUT, DVALID, LOCKED, ERRCNT, STATE);
    modport slave  (input  DATA_I, CHARISK_I, CHSEL, ERRCLR,
                    output DOUT, DVALID, LOCKED, ERRCNT, STATE);
endinterface

// File: rtl/gtp_chan_rx.sv
// GTP channel receiver: aligns to the periodic comma burst, tracks link lock,
// counts mismatched words and forwards samples carrying the selected tag.
module gtp_chan_rx #(
    parameter int LOCK_BURSTS = 2,
    parameter int LOSS_BURSTS = 4,
    parameter int PERIOD      = 1024,
    parameter int BURST       = 10
) (
    input  logic         CLK,
    input  logic         RST,
    gtp_chan_rx_if.slave bus
);
    typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCK = 2'd2} state_t;

    typedef struct packed {
        logic        comma;
        logic        data;
        logic [7:0]  idx;
        logic [3:0]  tag;
        logic [11:0] smp;
    } word_t;

    localparam logic [9:0] POS_LAST  = 10'(PERIOD - 1);
    localparam logic [9:0] POS_BURST = 10'(BURST);
    localparam logic [7:0] LOCK_N    = 8'(LOCK_BURSTS);
    localparam logic [7:0] LOSS_N    = 8'(LOSS_BURSTS);

    state_t      st, st_nxt;
    logic [9:0]  pos;
    logic [7:0]  gcnt, gcnt_nxt, bcnt, bcnt_nxt;
    logic        perr;
    logic [15:0] errcnt;
    logic [11:0] dout;
    logic        dvalid;
    word_t       w;
    logic        in_burst, exp_ok, mis, eop, good, hunt_hit, take;

    always_comb begin
        w.comma = (bus.CHARISK_I == 2'b01) && (bus.DATA_I[7:0] == 8'hBC);
        w.data  = (bus.CHARISK_I == 2'b00);
        w.idx   = bus.DATA_I[15:8];
        w.tag   = bus.DATA_I[15:12];
        w.smp   = bus.DATA_I[11:0];
    end

    // Tag filtering is separate from the expectation check: a foreign tag is
    // still a well-formed data word.
    assign in_burst = pos < POS_BURST;
    assign exp_ok   = in_burst ? (w.comma && ({2'b00, w.idx} == pos)) : w.data;
    assign mis      = (st != HUNT) && !exp_ok;
    assign eop      = (pos == POS_LAST);
    assign good     = !(perr || mis);
    assign hunt_hit = w.comma && (w.idx == 8'd0);
    assign take     = (st == LOCK) && !in_burst && w.data && (w.tag == bus.CHSEL);

    always_comb begin
        st_nxt   = st;
        gcnt_nxt = gcnt;
        bcnt_nxt = bcnt;
        unique case (st)
            HUNT: if (hunt_hit) st_nxt = CHECK;
            CHECK: begin
                if (mis) st_nxt = HUNT;
                else if (eop) begin
                    gcnt_nxt = gcnt + 8'd1;
                    if (gcnt_nxt >= LOCK_N) st_nxt = LOCK;
                end
            end
            LOCK: begin
                if (eop) begin
                    if (good) bcnt_nxt = '0;
                    else begin
                        bcnt_nxt = bcnt + 8'd1;
                        if (bcnt_nxt >= LOSS_N) st_nxt = HUNT;
                    end
                end
            end
            default: st_nxt = HUNT;
        endcase
        if (st_nxt != st) begin
            gcnt_nxt = '0;
            bcnt_nxt = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st     <= HUNT;
            pos    <= '0;
            gcnt   <= '0;
            bcnt   <= '0;
            perr   <= 1'b0;
            errcnt <= '0;
            dout   <= '0;
            dvalid <= 1'b0;
        end else begin
            st   <= st_nxt;
            gcnt <= gcnt_nxt;
            bcnt <= bcnt_nxt;
            // The index-0 comma itself occupies position 0, so the next word is 1.
            if (st == HUNT && hunt_hit) pos <= 10'd1;
            else if (eop)               pos <= '0;
            else                        pos <= pos + 10'd1;
            // Stale error flags must not leak into the next period or state.
            if (eop || st_nxt != st) perr <= 1'b0;
            else if (mis)            perr <= 1'b1;
            if (bus.ERRCLR)                         errcnt <= '0;
            else if (mis && errcnt != 16'hFFFF)     errcnt <= errcnt + 16'd1;
            dvalid <= take;
            if (take) dout <= w.smp;
        end
    end

    assign bus.DOUT   = dout;
    assign bus.DVALID = dvalid;
    assign bus.LOCKED = (st == LOCK);
    assign bus.ERRCNT = errcnt;
    assign bus.STATE  = st;
endmodule

// File: tb/tb_gtp_chan_rx.sv
// Directed bench for gtp_chan_rx: lock acquisition, tag filter, lock loss,
// CHECK abort, error counter saturation/clear and mid-period reset.
module tb_gtp_chan_rx;
    localparam int PERIOD = 1024;
    localparam int BURST  = 10;
    localparam int NO     = -1;

    logic CLK = 1'b0;
    logic RST;
    int   n_vec = 0;
    int   n_err = 0;

    gtp_chan_rx_if bus();

    gtp_chan_rx #(
        .LOCK_BURSTS(2), .LOSS_BURSTS(4), .PERIOD(PERIOD), .BURST(BURST)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #4 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One word per cycle: drive on the falling edge, return just after the
    // rising edge that consumed it.
    task automatic drive(input logic [15:0] d, input logic [1:0] k);
        @(negedge CLK);
        bus.DATA_I    = d;
        bus.CHARISK_I = k;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_words(input int lo, input int hi, input int bad_pos,
                             input logic [15:0] bad_w, input logic [1:0] bad_k,
                             input int clr_pos, input logic [3:0] tag_a,
                             input logic [3:0] tag_b, output int dv, output int derr,
                             output logic lk_pre, output logic [1:0] st_bad);
        logic [15:0] d;
        logic [1:0]  k;
        logic [3:0]  tg;
        logic [11:0] smp;
        dv     = 0;
        derr   = 0;
        lk_pre = 1'b0;
        st_bad = 2'd3;
        for (int p = lo; p <= hi; p++) begin
            tg  = p[0] ? tag_b : tag_a;
            smp = 12'(p) ^ 12'h5A0;
            if (p < BURST) begin
                d = {8'(p), 8'hBC};
                k = 2'b01;
            end else begin
                d = {tg, smp};
                k = 2'b00;
            end
            if (p == bad_pos) begin
                d = bad_w;
                k = bad_k;
            end
            bus.ERRCLR = (p == clr_pos);
            drive(d, k);
            if (bus.DVALID) begin
                dv++;
                if (bus.DOUT !== smp || tg !== bus.CHSEL || p < BURST) derr++;
            end
            if (p == PERIOD - 2) lk_pre = bus.LOCKED;
            if (p == bad_pos)    st_bad = bus.STATE;
        end
        bus.ERRCLR = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          dv, derr;
        logic        lk;
        logic [1:0]  sb;
        bus.DATA_I    = '0;
        bus.CHARISK_I = '0;
        bus.CHSEL     = 4'd3;
        bus.ERRCLR    = 1'b0;
        RST           = 1'b1;

        drive(16'h30AB, 2'b00);
        drive(16'h00BC, 2'b01);
        chk("rst_state",  32'(bus.STATE),  32'd0);
        chk("rst_locked", 32'(bus.LOCKED), 32'd0);
        chk("rst_dvalid", 32'(bus.DVALID), 32'd0);
        chk("rst_dout",   32'(bus.DOUT),   32'd0);
        chk("rst_errcnt", 32'(bus.ERRCNT), 32'd0);
        RST = 1'b0;

        // HUNT ignores everything but an index-0 comma and never counts errors
        for (int i = 0; i < 20; i++) drive({4'd3, 12'(i)}, 2'b00);
        drive(16'h0000, 2'b11);
        drive(16'h05BC, 2'b01);
        drive(16'h00BC, 2'b10);
        chk("hunt_state",  32'(bus.STATE),  32'd0);
        chk("hunt_errcnt", 32'(bus.ERRCNT), 32'd0);

        // clean stream: lock after two good periods
        run_words(0, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("p1_state", 32'(bus.STATE), 32'd1);
        chk("p1_dv",    32'(dv),        32'd0);
        run_words(0, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("p2_lkpre",  32'(lk),         32'd0);
        chk("p2_locked", 32'(bus.LOCKED), 32'd1);
        chk("p2_state",  32'(bus.STATE),  32'd2);
        chk("p2_dv",     32'(dv),         32'd0);
        run_words(0, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("p3_dv",     32'(dv),         32'd1014);
        chk("p3_derr",   32'(derr),       32'd0);
        chk("p3_errcnt", 32'(bus.ERRCNT), 32'd0);

        // tag filter: even positions tag 5, odd tag 6
        bus.CHSEL = 4'd5;
        run_words(0, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd5, 4'd6, dv, derr, lk, sb);
        chk("tag_dv",     32'(dv),         32'd507);
        chk("tag_derr",   32'(derr),       32'd0);
        chk("tag_errcnt", 32'(bus.ERRCNT), 32'd0);
        bus.CHSEL = 4'd3;

        // corrupt comma: index 4 at position 3
        run_words(0, PERIOD-1, 3, 16'h04BC, 2'b01, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("cc1_errcnt", 32'(bus.ERRCNT), 32'd1);
        chk("cc1_locked", 32'(bus.LOCKED), 32'd1);
        run_words(0, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("cc_clean_locked", 32'(bus.LOCKED), 32'd1);
        run_words(0, PERIOD-1, 3, 16'h04BC, 2'b01, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        run_words(0, PERIOD-1, 3, 16'h04BC, 2'b01, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        run_words(0, PERIOD-1, 3, 16'h04BC, 2'b01, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("cc3_locked", 32'(bus.LOCKED), 32'd1);
        run_words(0, PERIOD-1, 3, 16'h04BC, 2'b01, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("cc4_lkpre",  32'(lk),         32'd1);
        chk("cc4_locked", 32'(bus.LOCKED), 32'd0);
        chk("cc4_state",  32'(bus.STATE),  32'd0);
        chk("cc4_errcnt", 32'(bus.ERRCNT), 32'd5);

        // illegal K flags in CHECK abort immediately
        run_words(0, PERIOD-1, 500, 16'h3123, 2'b10, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("chk_abort_state", 32'(sb),          32'd0);
        chk("chk_end_state",   32'(bus.STATE),   32'd0);
        chk("chk_errcnt",      32'(bus.ERRCNT),  32'd6);
        run_words(0, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("relock1_state", 32'(bus.STATE), 32'd1);
        run_words(0, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("relock2_lkpre",  32'(lk),         32'd0);
        chk("relock2_locked", 32'(bus.LOCKED), 32'd1);

        // saturation and clear priority
        force dut.errcnt = 16'hFFFE;
        #1;
        release dut.errcnt;
        run_words(0, PERIOD-1, 3, 16'h04BC, 2'b01, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("sat_top", 32'(bus.ERRCNT), 32'h0000FFFF);
        run_words(0, PERIOD-1, 3, 16'h04BC, 2'b01, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("sat_hold",   32'(bus.ERRCNT), 32'h0000FFFF);
        chk("sat_locked", 32'(bus.LOCKED), 32'd1);
        run_words(0, PERIOD-1, 3, 16'h04BC, 2'b01, 3, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("clr_errcnt", 32'(bus.ERRCNT), 32'd0);
        chk("clr_locked", 32'(bus.LOCKED), 32'd1);
        run_words(0, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("post_clr_locked", 32'(bus.LOCKED), 32'd1);

        // reset at position 5 while locked
        run_words(0, 4, 3, 16'h04BC, 2'b01, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("prerst_errcnt", 32'(bus.ERRCNT), 32'd1);
        chk("prerst_dout",   32'(bus.DOUT),   32'h65F);
        chk("prerst_locked", 32'(bus.LOCKED), 32'd1);
        RST = 1'b1;
        drive(16'h05BC, 2'b01);
        chk("mrst_state",  32'(bus.STATE),  32'd0);
        chk("mrst_locked", 32'(bus.LOCKED), 32'd0);
        chk("mrst_dvalid", 32'(bus.DVALID), 32'd0);
        chk("mrst_dout",   32'(bus.DOUT),   32'd0);
        chk("mrst_errcnt", 32'(bus.ERRCNT), 32'd0);
        RST = 1'b0;
        run_words(6, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("mrst_tail_dv",    32'(dv),        32'd0);
        chk("mrst_tail_state", 32'(bus.STATE), 32'd0);
        run_words(0, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("mrst_c1_dv",    32'(dv),        32'd0);
        chk("mrst_c1_state", 32'(bus.STATE), 32'd1);
        run_words(0, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("mrst_c2_dv",     32'(dv),         32'd0);
        chk("mrst_c2_locked", 32'(bus.LOCKED), 32'd1);
        run_words(0, PERIOD-1, NO, 16'h0, 2'b00, NO, 4'd3, 4'd3, dv, derr, lk, sb);
        chk("mrst_l_dv",   32'(dv),   32'd1014);
        chk("mrst_l_derr", 32'(derr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
